// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared widths and types for the instruction prefetch buffer.
// These macros mirror defines.v and are only set when it is not already included.
// The optional macro PREFETCH_BYPASS_EN lets an empty buffer forward a response to the core in the same cycle.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef FETCH_STEP
`define FETCH_STEP 4
`endif
`ifndef PF_ENTRY_W
`define PF_ENTRY_W (`ADDR_SIZE+`INSTR_SIZE)
`endif

package instr_prefetch_buffer_pkg;

    localparam int unsigned ADDR_W     = `ADDR_SIZE;
    localparam int unsigned INSTR_W    = `INSTR_SIZE;
    localparam int unsigned ENTRY_W    = `PF_ENTRY_W;
    localparam int unsigned FETCH_STEP = `FETCH_STEP;

    // One buffered fetch: the instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } pf_entry_t;

    // Word-align a byte address by clearing its two low bits.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_prefetch_buffer_fifo.sv
// prefetch_fifo: synchronous DEPTH-entry FIFO with push, pop and flush.
// A flush wins over push and pop; a push into a full FIFO is accepted only when a pop frees a slot.
module prefetch_fifo
    import instr_prefetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        do_pop   = pop_i & (count_q != '0);
        do_push  = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (rst && !flush_i && do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: sequential instruction fetch with credit-limited memory requests,
// a small instruction FIFO toward the core, and redirect flush/drop of stale responses.
// Optional macro PREFETCH_BYPASS_EN: an empty buffer forwards a live response to a ready core in the same cycle.
module instr_prefetch_buffer
    import instr_prefetch_buffer_pkg::*;
#(
    parameter int unsigned       DEPTH           = 4,
    parameter int unsigned       MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC        = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_rsp_valid,
    input  logic [INSTR_W-1:0] mem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [OUT_W-1:0]  in_flight_q, in_flight_d;
    logic [OUT_W-1:0]  drop_cnt_q, drop_cnt_d;
    pf_entry_t         hold_q, hold_d;

    pf_entry_t         rsp_entry, fifo_head, shown;
    logic [CNT_W-1:0]  fifo_count;
    logic [SUM_W-1:0]  live_cnt;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic              req_hs, rsp_live, bypass_c;

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (fifo_push),
        .push_data_i (rsp_entry),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Request credit: every live request must have a guaranteed FIFO slot when it returns.
    always_comb begin
        live_cnt      = SUM_W'(in_flight_q) - SUM_W'(drop_cnt_q);
        mem_req_valid = rst & ~redirect_valid & ~fifo_full
                      & ((SUM_W'(fifo_count) + live_cnt) < SUM_W'(DEPTH))
                      & (in_flight_q < OUT_W'(MAX_OUTSTANDING));
        mem_req_addr  = fetch_pc_q;
        req_hs        = mem_req_valid & mem_req_ready;
    end

    // Response routing and core-facing outputs; instr/instr_pc hold the last shown head when idle.
    always_comb begin
        rsp_entry.pc    = rsp_pc_q;
        rsp_entry.instr = mem_rsp_data;
        rsp_live        = mem_rsp_valid & ~redirect_valid & (drop_cnt_q == '0);
`ifdef PREFETCH_BYPASS_EN
        bypass_c        = rsp_live & fifo_empty & instr_ready;
`else
        bypass_c        = 1'b0;
`endif
        fifo_push       = rsp_live & ~bypass_c;
        fifo_pop        = ~fifo_empty & instr_ready & ~redirect_valid;
        shown           = bypass_c ? rsp_entry : fifo_head;
        instr_valid     = rst & (~fifo_empty | bypass_c);
        hold_d          = instr_valid ? shown : hold_q;
        instr           = hold_d.instr;
        instr_pc        = hold_d.pc;
    end

    // Fetch/response PC tracking and in-flight/drop accounting; redirect takes priority.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        rsp_pc_d    = rsp_pc_q;
        drop_cnt_d  = drop_cnt_q;
        in_flight_d = in_flight_q + OUT_W'(req_hs) - OUT_W'(mem_rsp_valid);
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            rsp_pc_d   = word_align(redirect_pc);
            drop_cnt_d = in_flight_d;
        end else begin
            if (req_hs) fetch_pc_d = fetch_pc_q + ADDR_W'(FETCH_STEP);
            if (mem_rsp_valid) begin
                if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - OUT_W'(1);
                else                  rsp_pc_d   = rsp_pc_q + ADDR_W'(FETCH_STEP);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q  <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            in_flight_q <= '0;
            drop_cnt_q  <= '0;
            hold_q      <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            in_flight_q <= in_flight_d;
            drop_cnt_q  <= drop_cnt_d;
            hold_q      <= hold_d;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Self-checking bench for instr_prefetch_buffer: a behavioural instruction memory with random
// latency/backpressure and a reference model of the PC stream the core must observe.
module tb_instr_prefetch_buffer;

    localparam int          DEPTH    = 4;
    localparam int          MAXO     = 2;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef PREFETCH_BYPASS_EN
    localparam int          FIRST_VALID = 1;
`else
    localparam int          FIRST_VALID = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    instr_prefetch_buffer #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Instruction memory contents as a pure function of the word address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    // Memory model: accepted requests awaiting an in-order response.
    logic [31:0] q_addr [$];
    int          q_due  [$];
    int          last_due = 0;
    int          cyc = 0;

    // Stimulus knobs.
    int          mem_rdy_pct = 100;
    int          rdy_pct     = 100;
    int          lat_lo      = 1;
    int          lat_hi      = 1;
    int          redir_pct   = 0;
    bit          force_redir = 0;
    logic [31:0] force_tgt   = 32'h0;

    // Reference state: next fetch address and next PC the core must receive.
    logic [31:0] exp_fetch, exp_pop;
    bit          prev_redir, shown, post_reset;
    logic [31:0] last_pc, last_ins;
    int          hs_cnt = 0;
    int          pop_cnt = 0;

    // Per-step observations.
    bit          last_iv, last_rv, last_pop;
    logic [31:0] last_ra, last_pop_pc;

    // One clock cycle: drive inputs in the low phase, sample, check, update the models.
    task automatic step();
        bit          rsp_now;
        logic [31:0] tgt;
        logic [31:0] dummy_a;
        int          dummy_d, lat, due, outstanding;
        mem_req_ready  = ($urandom_range(99) < mem_rdy_pct);
        instr_ready    = ($urandom_range(99) < rdy_pct);
        redirect_valid = force_redir || ($urandom_range(99) < redir_pct);
        tgt            = force_redir ? force_tgt : $urandom();
        redirect_pc    = tgt;
        force_redir    = 0;
        outstanding    = q_addr.size();
        rsp_now        = (outstanding > 0) && (q_due[0] <= cyc);
        mem_rsp_valid  = rsp_now;
        mem_rsp_data   = rsp_now ? imem(q_addr[0]) : $urandom();
        #1;
        last_iv  = instr_valid;
        last_rv  = mem_req_valid;
        last_ra  = mem_req_addr;
        last_pop = 0;
        if (post_reset) begin
            check_eq("first_req_valid", 32'(mem_req_valid), 32'd1);
            check_eq("first_req_addr", mem_req_addr, RESET_PC);
            check_eq("reset_instr_valid", 32'(instr_valid), 32'd0);
            check_eq("reset_instr", instr, 32'd0);
            check_eq("reset_instr_pc", instr_pc, 32'd0);
            post_reset = 0;
        end
        if (redirect_valid) check_eq("no_req_on_redirect", 32'(mem_req_valid), 32'd0);
        if (prev_redir)     check_eq("valid_after_redirect", 32'(instr_valid), 32'd0);
        if (!instr_valid && shown) begin
            check_eq("hold_pc", instr_pc, last_pc);
            check_eq("hold_instr", instr, last_ins);
        end
        if (mem_req_valid && mem_req_ready) begin
            check_eq("req_addr", mem_req_addr, exp_fetch);
            check_eq("outstanding_limit", 32'(outstanding < MAXO), 32'd1);
            exp_fetch = exp_fetch + 32'd4;
            lat = $urandom_range(lat_hi, lat_lo);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            q_addr.push_back(mem_req_addr);
            q_due.push_back(due);
            hs_cnt++;
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
            check_eq("instr_pc", instr_pc, exp_pop);
            check_eq("instr", instr, imem(exp_pop));
            last_pop    = 1;
            last_pop_pc = instr_pc;
            exp_pop     = exp_pop + 32'd4;
            pop_cnt++;
        end
        if (instr_valid) begin
            shown    = 1;
            last_pc  = instr_pc;
            last_ins = instr;
        end
        if (rsp_now) begin
            dummy_a = q_addr.pop_front();
            dummy_d = q_due.pop_front();
        end
        if (redirect_valid) begin
            exp_fetch = {tgt[31:2], 2'b00};
            exp_pop   = {tgt[31:2], 2'b00};
        end
        prev_redir = redirect_valid;
        cyc++;
        @(negedge clk);
    endtask

    // Synchronous reset; memory shares it so pending responses vanish.
    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_req_ready  = 1'b1;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 32'h0;
        instr_ready    = 1'b0;
        q_addr.delete();
        q_due.delete();
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_instr_pc", instr_pc, 32'd0);
        rst        = 1'b1;
        exp_fetch  = RESET_PC;
        exp_pop    = RESET_PC;
        shown      = 0;
        prev_redir = 0;
        post_reset = 1;
        last_due   = cyc;
    endtask

    task automatic wait_pop(input string tag, input logic [31:0] exp_pc);
        bit got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (last_pop) begin
                got = 1;
                check_eq(tag, last_pop_pc, exp_pc);
            end
        end
        if (!got) check_eq({tag, "_timeout"}, 32'(got), 32'd1);
    endtask

    initial begin
        int hs0, p0;
        logic [31:0] wrap_addr [3];
        wrap_addr[0] = 32'hFFFFFFF8;
        wrap_addr[1] = 32'hFFFFFFFC;
        wrap_addr[2] = 32'h00000000;

        do_reset();

        // Streaming at latency 1: first valid after the fill latency, then no gaps.
        for (int i = 0; i < 12; i++) begin
            step();
            check_eq($sformatf("fill_valid_%0d", i), 32'(last_iv), 32'(i >= FIRST_VALID));
        end

        // Redirect coinciding with a response and a pop.
        force_redir = 1;
        force_tgt   = 32'h80;
        step();
        check_eq("redir_pop_valid", 32'(last_iv), 32'd1);
        step();
        check_eq("redir_next_req_valid", 32'(last_rv), 32'd1);
        check_eq("redir_next_req_addr", last_ra, 32'h80);
        repeat (4) step();

        // Unaligned redirect target and fetch address wrap.
        force_redir = 1;
        force_tgt   = 32'h203;
        step();
        step();
        check_eq("unaligned_target", last_ra, 32'h200);
        wait_pop("unaligned_first_pop", 32'h200);
        force_redir = 1;
        force_tgt   = 32'hFFFFFFF8;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("wrap_addr_%0d", i), last_ra, wrap_addr[i]);
        end
        repeat (6) step();

        // Latency 3 with two requests in flight, then redirect: both responses dropped.
        lat_lo = 3;
        lat_hi = 3;
        force_redir = 1;
        force_tgt   = 32'h40;
        step();
        step();
        step();
        force_redir = 1;
        force_tgt   = 32'h100;
        step();
        wait_pop("drop_first_pop", 32'h100);
        wait_pop("drop_second_pop", 32'h104);
        lat_lo = 1;
        lat_hi = 1;

        // Core stalled after reset: exactly DEPTH fetches buffered, then the stream resumes intact.
        do_reset();
        rdy_pct = 0;
        hs0 = hs_cnt;
        repeat (20) step();
        check_eq("stall_fetches", 32'(hs_cnt - hs0), 32'(DEPTH));
        check_eq("stall_req_valid", 32'(last_rv), 32'd0);
        check_eq("stall_instr_valid", 32'(last_iv), 32'd1);
        check_eq("stall_head_pc", instr_pc, 32'h0);
        rdy_pct = 100;
        wait_pop("stall_resume_pop", 32'h0);
        repeat (10) step();

        // Random backpressure, latency and redirects.
        mem_rdy_pct = 70;
        rdy_pct     = 70;
        lat_lo      = 1;
        lat_hi      = 4;
        redir_pct   = 3;
        repeat (3000) step();

        // Drain with everything ready: delivery must keep going.
        mem_rdy_pct = 100;
        rdy_pct     = 100;
        lat_lo      = 1;
        lat_hi      = 1;
        redir_pct   = 0;
        repeat (10) step();
        p0 = pop_cnt;
        repeat (40) step();
        check_eq("drain_progress", 32'(pop_cnt - p0 >= 30), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
